// File: rtl/fp_iter_normalizer.sv
// Iterative post-add/sub mantissa normalizer.
// Shifts the mantissa left one bit per cycle and decrements the exponent on
// each shift. It stops when the MSB is set or the exponent reaches zero.
// The block holds one operand at a time, with valid/ready on both sides.
module fp_iter_normalizer #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_WIDTH-1:0] in_mant,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_WIDTH-1:0] out_mant,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic                  out_zero,
    output logic                  out_underflow,
    output logic                  busy
);

    localparam int MSB = MANT_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [MANT_WIDTH-1:0] mant_q;
    logic [EXP_WIDTH-1:0]  exp_q;
    logic                  zero_q;
    logic                  uf_q;
    logic                  accept;
    logic                  in_is_zero;
    logic                  no_shift_needed;
    logic                  shift_last;

    assign accept          = in_valid & in_ready;
    assign in_is_zero      = (in_mant == '0);
    assign no_shift_needed = in_mant[MSB] | (in_exp == '0);
    // The shift happening now is the final one when it brings a one into the
    // MSB or when it takes the exponent down to zero.
    assign shift_last      = mant_q[MSB-1] | (exp_q == EXP_WIDTH'(1));

    // The state register. Reset aborts any operand that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Operands that need no shifting go straight to DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_is_zero || no_shift_needed) begin
                        next_state = DONE;
                    end else begin
                        next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs are decoded directly from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // The datapath loads on accept and shifts once per SHIFT cycle. The
    // underflow flag is valid from the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mant_q <= in_mant;
                        zero_q <= in_is_zero;
                        if (in_is_zero) begin
                            exp_q <= '0;
                            uf_q  <= 1'b0;
                        end else begin
                            exp_q <= in_exp;
                            uf_q  <= ~in_mant[MSB] & (in_exp == '0);
                        end
                    end
                end
                SHIFT: begin
                    mant_q <= {mant_q[MSB-1:0], 1'b0};
                    exp_q  <= exp_q - EXP_WIDTH'(1);
                    uf_q   <= ~mant_q[MSB-1];
                end
                default: begin
                end
            endcase
        end
    end

    assign out_mant      = mant_q;
    assign out_exp       = exp_q;
    assign out_zero      = zero_q;
    assign out_underflow = uf_q;

endmodule

// File: tb/tb_fp_iter_normalizer.sv
// Directed testbench for fp_iter_normalizer with MANT_WIDTH=24 and EXP_WIDTH=8.
// In this bench, latency is the number of rising edges after the accept edge
// until out_valid is high. An operand that needs no shift is therefore valid
// right after the accept edge.
module tb_fp_iter_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_underflow;
    logic        busy;

    int total;
    int bad;

    fp_iter_normalizer #(
        .MANT_WIDTH(24),
        .EXP_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mant      (in_mant),
        .in_exp       (in_exp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mant     (out_mant),
        .out_exp      (out_exp),
        .out_zero     (out_zero),
        .out_underflow(out_underflow),
        .busy         (busy)
    );

    // The clock has a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand for a single edge. Afterwards the inputs are
    // scrambled, and the DUT must ignore that.
    task automatic send(input logic [23:0] m, input logic [7:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mant  = 24'($urandom);
        in_exp   = 8'($urandom);
    endtask

    // Counts edges until out_valid is high. The count is bounded so that a
    // hung DUT shows up as a latency mismatch.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Completes the output handshake with a one-edge pulse of out_ready.
    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Checks that all outputs are cleared in reset and that the block is
    // ready once reset is released.
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_zero !== 1'b0 || out_underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got v=%b busy=%b z=%b uf=%b expected all 0",
                     out_valid, busy, out_zero, out_underflow);
        end
        total++;
        if (out_mant !== 24'h0 || out_exp !== 8'h0) begin
            bad++;
            $display("[TB] FAIL reset_regs: got mant=%h exp=%h expected 000000/00", out_mant, out_exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    // Case 1: the MSB is already set, so no shift happens.
    task automatic test_no_shift();
        int cyc;
        send(24'h800000, 8'h80);
        wait_valid(cyc);
        total++;
        if (cyc !== 0) begin
            bad++;
            $display("[TB] FAIL no_shift_latency: got %0d expected 0", cyc);
        end
        total++;
        if (out_mant !== 24'h800000 || out_exp !== 8'h80 || out_zero !== 1'b0 || out_underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL no_shift_result: got %h/%h z=%b uf=%b expected 800000/80 z=0 uf=0",
                     out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL no_shift_drain: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    // Case 2: 23 shifts, the maximum. busy must stay high on every cycle.
    task automatic test_long_shift();
        int cyc;
        int busy_low;
        busy_low = 0;
        send(24'h000001, 8'h80);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_low++;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc !== 23) begin
            bad++;
            $display("[TB] FAIL long_latency: got %0d expected 23", cyc);
        end
        total++;
        if (busy_low !== 0) begin
            bad++;
            $display("[TB] FAIL long_busy: got %0d cycles not busy expected 0", busy_low);
        end
        total++;
        if (out_mant !== 24'h800000 || out_exp !== 8'h69 || out_zero !== 1'b0 || out_underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL long_result: got %h/%h z=%b uf=%b expected 800000/69 z=0 uf=0",
                     out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
    endtask

    // Case 3: the exponent runs out after 5 shifts, which gives a denormal.
    task automatic test_underflow();
        int cyc;
        send(24'h001000, 8'h05);
        wait_valid(cyc);
        total++;
        if (cyc !== 5) begin
            bad++;
            $display("[TB] FAIL uf_latency: got %0d expected 5", cyc);
        end
        total++;
        if (out_mant !== 24'h020000 || out_exp !== 8'h00 || out_zero !== 1'b0 || out_underflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL uf_result: got %h/%h z=%b uf=%b expected 020000/00 z=0 uf=1",
                     out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
    endtask

    // Case 4: a zero mantissa forces exp to 0 and sets the zero flag.
    task automatic test_zero();
        int cyc;
        send(24'h000000, 8'h55);
        wait_valid(cyc);
        total++;
        if (cyc !== 0) begin
            bad++;
            $display("[TB] FAIL zero_latency: got %0d expected 0", cyc);
        end
        total++;
        if (out_mant !== 24'h000000 || out_exp !== 8'h00 || out_zero !== 1'b1 || out_underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_result: got %h/%h z=%b uf=%b expected 000000/00 z=1 uf=0",
                     out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
    endtask

    // Exponent boundaries: exp=0 input, and exp=1 allowing a single shift.
    task automatic test_exp_edges();
        int cyc;
        send(24'h400000, 8'h00);
        wait_valid(cyc);
        total++;
        if (cyc !== 0 || out_mant !== 24'h400000 || out_exp !== 8'h00 || out_underflow !== 1'b1 || out_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL exp0_result: got lat=%0d %h/%h z=%b uf=%b expected lat=0 400000/00 z=0 uf=1",
                     cyc, out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
        send(24'h200000, 8'h01);
        wait_valid(cyc);
        total++;
        if (cyc !== 1 || out_mant !== 24'h400000 || out_exp !== 8'h00 || out_underflow !== 1'b1 || out_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL exp1_result: got lat=%0d %h/%h z=%b uf=%b expected lat=1 400000/00 z=0 uf=1",
                     cyc, out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
    endtask

    // Case 5: the consumer holds off for 10 cycles while a new operand is
    // pending. The result must stay frozen and the new operand must wait.
    task automatic test_back_to_back();
        int cyc;
        int unstable;
        unstable = 0;
        send(24'h000001, 8'h80);
        wait_valid(cyc);
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 24'h400000;
        in_exp   = 8'h10;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mant !== 24'h800000 ||
                out_exp !== 8'h69 || out_zero !== 1'b0 || out_underflow !== 1'b0) unstable++;
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", unstable);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL release_ready: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        total++;
        if (cyc !== 1 || out_mant !== 24'h800000 || out_exp !== 8'h0F || out_underflow !== 1'b0 || out_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL next_op: got lat=%0d %h/%h z=%b uf=%b expected lat=1 800000/0f z=0 uf=0",
                     cyc, out_mant, out_exp, out_zero, out_underflow);
        end
        drain();
    endtask

    // Case 6: reset in the middle of the SHIFT state discards the operand.
    task automatic test_reset_abort();
        int stale;
        stale = 0;
        send(24'h000001, 8'h80);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_pre: got busy=%b v=%b expected busy=1 v=0", busy, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_drop: got busy=%b v=%b expected 0/0", busy, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_ready: got %b expected 1", in_ready);
        end
        out_ready = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        out_ready = 1'b0;
        total++;
        if (stale !== 0) begin
            bad++;
            $display("[TB] FAIL abort_stale: got %0d cycles with output expected 0", stale);
        end
    endtask

    // The test sequence.
    initial begin
        total     = 0;
        bad       = 0;
        in_valid  = 1'b0;
        in_mant   = 24'h0;
        in_exp    = 8'h0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_no_shift();
        test_long_shift();
        test_underflow();
        test_zero();
        test_exp_edges();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
